// File: rtl/acc_addsub_ctrl.sv
// Valid/ready sequencing controller around an external 4-bit ripple add/subtract
// datapath; keeps the accumulator, last carry/overflow and a sticky overflow flag.
module acc_addsub_ctrl #(
    parameter int WIDTH  = 4,
    parameter bit SAT_EN = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [WIDTH-1:0] in_data,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    output logic             add_m,
    input  logic [WIDTH-1:0] add_s,
    input  logic             add_c4,
    input  logic             add_v,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] acc,
    output logic             carry,
    output logic             ovf,
    output logic             ovf_sticky,
    output logic [7:0]       op_count
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_ADD   = 2'b01;
    localparam logic [1:0] OP_SUB   = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    // Saturation bound chosen by the pre-op sign: positive overflow clamps to max, negative to min.
    function automatic logic [WIDTH-1:0] sat_value(input logic sign);
        sat_value = {sign, {(WIDTH-1){~sign}}};
    endfunction

    state_t             state_r;
    state_t             state_nxt_s;
    logic [1:0]         op_r;
    logic [WIDTH-1:0]   b_r;
    logic [WIDTH-1:0]   acc_r;
    logic               carry_r;
    logic               ovf_r;
    logic               sticky_r;
    logic [7:0]         count_r;
    logic               in_ready_r;
    logic               out_valid_r;

    logic [WIDTH-1:0]   res_acc_s;
    logic               res_carry_s;
    logic               res_ovf_s;
    logic               res_sticky_s;
    logic [WIDTH-1:0]   add_b_s;
    logic               add_m_s;

    // Next-state decode, adder drive and the EXEC result selection.
    always_comb begin
        state_nxt_s  = state_r;
        add_b_s      = {WIDTH{1'b0}};
        add_m_s      = 1'b0;
        res_acc_s    = acc_r;
        res_carry_s  = carry_r;
        res_ovf_s    = ovf_r;
        res_sticky_s = sticky_r;
        case (state_r)
            ST_IDLE: begin
                if (in_valid) begin
                    state_nxt_s = ST_EXEC;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_EXEC: begin
                state_nxt_s = ST_RESP;
                add_b_s     = b_r;
                add_m_s     = (op_r == OP_SUB);
                case (op_r)
                    OP_LOAD: begin
                        res_acc_s   = b_r;
                        res_carry_s = 1'b0;
                        res_ovf_s   = 1'b0;
                    end
                    OP_ADD, OP_SUB: begin
                        res_acc_s    = (SAT_EN && add_v) ? sat_value(acc_r[WIDTH-1]) : add_s;
                        res_carry_s  = add_c4;
                        res_ovf_s    = add_v;
                        res_sticky_s = sticky_r | add_v;
                    end
                    OP_CLEAR: begin
                        res_acc_s    = {WIDTH{1'b0}};
                        res_carry_s  = 1'b0;
                        res_ovf_s    = 1'b0;
                        res_sticky_s = 1'b0;
                    end
                    default: begin
                        res_acc_s = acc_r;
                    end
                endcase
            end
            ST_RESP: begin
                if (out_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RESP;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State, request capture, result registers and handshake flags; reset wins over everything.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            op_r        <= 2'b00;
            b_r         <= {WIDTH{1'b0}};
            acc_r       <= {WIDTH{1'b0}};
            carry_r     <= 1'b0;
            ovf_r       <= 1'b0;
            sticky_r    <= 1'b0;
            count_r     <= 8'd0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            in_ready_r  <= (state_nxt_s == ST_IDLE);
            out_valid_r <= (state_nxt_s == ST_RESP);
            if (state_r == ST_IDLE && in_valid) begin
                op_r <= in_op;
                b_r  <= in_data;
            end
            if (state_r == ST_EXEC) begin
                acc_r    <= res_acc_s;
                carry_r  <= res_carry_s;
                ovf_r    <= res_ovf_s;
                sticky_r <= res_sticky_s;
            end
            if (state_r == ST_RESP && out_ready) begin
                count_r <= count_r + 8'd1;
            end
        end
    end

    assign in_ready   = in_ready_r;
    assign out_valid  = out_valid_r;
    assign add_a      = acc_r;
    assign add_b      = add_b_s;
    assign add_m      = add_m_s;
    assign acc        = acc_r;
    assign carry      = carry_r;
    assign ovf        = ovf_r;
    assign ovf_sticky = sticky_r;
    assign op_count   = count_r;

endmodule

// File: tb/tb_acc_addsub_ctrl.sv
// Directed bench for acc_addsub_ctrl: a wrapping and a saturating instance share
// stimulus, each fed by its own behavioural 4-bit ripple add/subtract model.
module tb_acc_addsub_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [1:0] in_op;
    logic [3:0] in_data;
    logic       out_ready;

    logic       in_ready0, add_m0, add_c40, add_v0, out_valid0, carry0, ovf0, sticky0;
    logic [3:0] add_a0, add_b0, add_s0, acc0;
    logic [7:0] count0;
    logic       in_ready1, add_m1, add_c41, add_v1, out_valid1, carry1, ovf1, sticky1;
    logic [3:0] add_a1, add_b1, add_s1, acc1;
    logic [7:0] count1;

    int errors = 0;
    int checks = 0;

    // Values captured during EXEC and RESP by run_op
    logic [3:0] x_a, x_b;
    logic       x_m, x_ready, x_valid;
    logic       r_valid, r_ready;
    logic [3:0] r_b;

    localparam logic [1:0] LOAD = 2'b00, ADD = 2'b01, SUB = 2'b10, CLR = 2'b11;

    always #5 clk = ~clk;

    // Returns {V, C4, S}: subtract is A + ~B + 1.
    function automatic logic [5:0] add4(input logic [3:0] a, input logic [3:0] b, input logic m);
        logic [3:0] be;
        logic [4:0] sum;
        logic       v;
        be  = m ? ~b : b;
        sum = {1'b0, a} + {1'b0, be} + {4'b0000, m};
        v   = (a[3] == be[3]) && (sum[3] != a[3]);
        return {v, sum[4], sum[3:0]};
    endfunction

    always_comb {add_v0, add_c40, add_s0} = add4(add_a0, add_b0, add_m0);
    always_comb {add_v1, add_c41, add_s1} = add4(add_a1, add_b1, add_m1);

    acc_addsub_ctrl #(.WIDTH(4), .SAT_EN(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
        .in_op(in_op), .in_data(in_data), .add_a(add_a0), .add_b(add_b0), .add_m(add_m0),
        .add_s(add_s0), .add_c4(add_c40), .add_v(add_v0), .out_valid(out_valid0),
        .out_ready(out_ready), .acc(acc0), .carry(carry0), .ovf(ovf0),
        .ovf_sticky(sticky0), .op_count(count0)
    );

    acc_addsub_ctrl #(.WIDTH(4), .SAT_EN(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
        .in_op(in_op), .in_data(in_data), .add_a(add_a1), .add_b(add_b1), .add_m(add_m1),
        .add_s(add_s1), .add_c4(add_c41), .add_v(add_v1), .out_valid(out_valid1),
        .out_ready(out_ready), .acc(acc1), .carry(carry1), .ovf(ovf1),
        .ovf_sticky(sticky1), .op_count(count1)
    );

    // One full transaction with out_ready high; entered and left at 1 time unit after a rising edge.
    task automatic run_op(input logic [1:0] op, input logic [3:0] data);
        in_valid = 1'b1; in_op = op; in_data = data; out_ready = 1'b1;
        @(posedge clk); #1;
        x_a = add_a0; x_b = add_b0; x_m = add_m0; x_ready = in_ready0; x_valid = out_valid0;
        in_valid = 1'b0; in_op = 2'b00; in_data = 4'hF;
        @(posedge clk); #1;
        r_valid = out_valid0; r_ready = in_ready0; r_b = add_b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; in_valid = 1'b0; in_op = 2'b00; in_data = 4'h0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (acc0 !== 4'h0) begin errors++; $display("FAIL reset_acc: got %b want 0000", acc0); end
        checks++; if ({carry0, ovf0, sticky0} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b want 000", {carry0, ovf0, sticky0}); end
        checks++; if (count0 !== 8'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", count0); end
        checks++; if ({in_ready0, out_valid0} !== 2'b10) begin errors++; $display("FAIL reset_hs: got %b want 10", {in_ready0, out_valid0}); end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_load_add;
        run_op(LOAD, 4'd3);
        run_op(ADD, 4'd4);
        checks++; if ({x_ready, x_valid} !== 2'b00) begin errors++; $display("FAIL exec_hs: got %b want 00", {x_ready, x_valid}); end
        checks++; if ({r_valid, r_ready} !== 2'b10) begin errors++; $display("FAIL resp_hs: got %b want 10", {r_valid, r_ready}); end
        checks++; if (x_a !== 4'd3 || x_b !== 4'd4 || x_m !== 1'b0) begin errors++; $display("FAIL add_drive: got a=%b b=%b m=%b want 0011 0100 0", x_a, x_b, x_m); end
        checks++; if (r_b !== 4'd0) begin errors++; $display("FAIL quiet_b: got %b want 0000", r_b); end
        checks++; if (acc0 !== 4'b0111 || carry0 !== 1'b0 || ovf0 !== 1'b0) begin errors++; $display("FAIL add_result: got %b c=%b v=%b want 0111 0 0", acc0, carry0, ovf0); end
        checks++; if (count0 !== 8'd2 || out_valid0 !== 1'b0 || in_ready0 !== 1'b1) begin errors++; $display("FAIL add_done: got cnt=%0d ov=%b ir=%b want 2 0 1", count0, out_valid0, in_ready0); end
    endtask

    task automatic test_overflow;
        run_op(ADD, 4'd1);
        checks++; if ({acc0, carry0, ovf0, sticky0} !== 7'b1000_011) begin errors++; $display("FAIL wrap_ovf: got %b want 1000011", {acc0, carry0, ovf0, sticky0}); end
        checks++; if ({acc1, carry1, ovf1, sticky1} !== 7'b0111_011) begin errors++; $display("FAIL sat_ovf: got %b want 0111011", {acc1, carry1, ovf1, sticky1}); end
    endtask

    task automatic test_sub;
        run_op(LOAD, 4'd5);
        run_op(SUB, 4'd3);
        checks++; if (x_m !== 1'b1 || x_b !== 4'b0011 || x_a !== 4'b0101) begin errors++; $display("FAIL sub_drive: got a=%b b=%b m=%b want 0101 0011 1", x_a, x_b, x_m); end
        checks++; if ({acc0, carry0, ovf0} !== 6'b0010_10) begin errors++; $display("FAIL sub3: got %b want 001010", {acc0, carry0, ovf0}); end
        run_op(SUB, 4'd4);
        checks++; if ({acc0, carry0, ovf0} !== 6'b1110_00) begin errors++; $display("FAIL sub4: got %b want 111000", {acc0, carry0, ovf0}); end
        checks++; if (count0 !== 8'd6) begin errors++; $display("FAIL sub_count: got %0d want 6", count0); end
    endtask

    task automatic test_backpressure;
        in_valid = 1'b1; in_op = LOAD; in_data = 4'd9; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            in_valid = (i == 1); in_op = CLR; in_data = 4'd0;
            @(posedge clk); #1;
            checks++; if ({out_valid0, in_ready0, acc0} !== 6'b10_1001) begin errors++; $display("FAIL hold_%0d: got %b want 101001", i, {out_valid0, in_ready0, acc0}); end
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        checks++; if ({out_valid0, in_ready0} !== 2'b01 || count0 !== 8'd7) begin errors++; $display("FAIL release: got ov=%b ir=%b cnt=%0d want 0 1 7", out_valid0, in_ready0, count0); end
        @(posedge clk); #1;
        checks++; if (count0 !== 8'd7 || acc0 !== 4'b1001 || out_valid0 !== 1'b0) begin errors++; $display("FAIL ignored_req: got cnt=%0d acc=%b ov=%b want 7 1001 0", count0, acc0, out_valid0); end
    endtask

    task automatic test_sticky;
        run_op(LOAD, 4'd7);
        run_op(ADD, 4'd1);
        run_op(LOAD, 4'd2);
        checks++; if ({acc0, ovf0, sticky0} !== 6'b0010_01) begin errors++; $display("FAIL sticky_load: got %b want 001001", {acc0, ovf0, sticky0}); end
        run_op(CLR, 4'd5);
        checks++; if ({acc0, carry0, ovf0, sticky0} !== 7'b0) begin errors++; $display("FAIL clear: got %b want 0000000", {acc0, carry0, ovf0, sticky0}); end
        checks++; if (count0 !== 8'd11) begin errors++; $display("FAIL sticky_count: got %0d want 11", count0); end
    endtask

    task automatic test_reset_mid;
        run_op(LOAD, 4'd4);
        in_valid = 1'b1; in_op = ADD; in_data = 4'd6;
        @(posedge clk); #1;
        in_valid = 1'b0; rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        checks++; if ({acc0, carry0, ovf0, sticky0, out_valid0, in_ready0} !== 9'b0000_0000_1 || count0 !== 8'd0) begin errors++; $display("FAIL rst_exec: got %b cnt=%0d want 000000001 0", {acc0, carry0, ovf0, sticky0, out_valid0, in_ready0}, count0); end
        @(posedge clk); #1;
        checks++; if (out_valid0 !== 1'b0) begin errors++; $display("FAIL rst_exec_drop: got ov=%b want 0", out_valid0); end
        in_valid = 1'b1; in_op = LOAD; in_data = 4'd6; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        checks++; if (out_valid0 !== 1'b1 || acc0 !== 4'd6) begin errors++; $display("FAIL pre_rst_resp: got ov=%b acc=%b want 1 0110", out_valid0, acc0); end
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1; out_ready = 1'b1;
        checks++; if ({acc0, out_valid0, in_ready0} !== 6'b0000_01 || count0 !== 8'd0) begin errors++; $display("FAIL rst_resp: got %b cnt=%0d want 000001 0", {acc0, out_valid0, in_ready0}, count0); end
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 255; i++) run_op(ADD, 4'd1);
        checks++; if (count0 !== 8'd255 || acc0 !== 4'hF) begin errors++; $display("FAIL b2b_255: got cnt=%0d acc=%b want 255 1111", count0, acc0); end
        run_op(ADD, 4'd1);
        checks++; if (count0 !== 8'd0 || acc0 !== 4'h0 || carry0 !== 1'b1) begin errors++; $display("FAIL count_wrap: got cnt=%0d acc=%b c=%b want 0 0000 1", count0, acc0, carry0); end
    endtask

    initial begin
        test_reset;
        test_load_add;
        test_overflow;
        test_sub;
        test_backpressure;
        test_sticky;
        test_reset_mid;
        test_back_to_back;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
